// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: one-entry output register plus skid buffer, with
// redirect flush and a drain state for a request left outstanding by a redirect.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall_IF,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ack,
  input  logic [31:0] Imem_Rdata,
  output logic [31:0] Instruction_IF,
  output logic [31:0] PC_Plus_4_IF,
  output logic        Valid_IF
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] stale_reg, stale_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc4_reg, pc4_next;
  logic        valid_reg, valid_next;
  logic [31:0] skid_instr_reg, skid_instr_next;
  logic [31:0] skid_pc4_reg, skid_pc4_next;
  logic        skid_valid_reg, skid_valid_next;

  logic [31:0] pc_plus_4;
  logic [31:0] addr_raw;
  logic        ack;
  logic        consume;
  logic        room;
  logic [1:0]  unused_redirect_lo;

  assign unused_redirect_lo = Redirect_PC[1:0];
  assign pc_plus_4 = pc_reg + 32'd4;
  assign consume   = valid_reg && !Stall_IF;
  assign room      = !valid_reg || !Stall_IF;

  // The request is withdrawn only while parked in HOLD or held in reset.
  assign Imem_Req  = Reset_n && (state_reg != HOLD);
  assign addr_raw  = (state_reg == DRAIN) ? stale_reg : pc_reg;
  assign Imem_Addr = {addr_raw[31:2], 2'b00};
  assign ack       = Imem_Ack && Imem_Req;

  assign Instruction_IF = instr_reg;
  assign PC_Plus_4_IF   = pc4_reg;
  assign Valid_IF       = valid_reg;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    stale_next      = stale_reg;
    instr_next      = instr_reg;
    pc4_next        = pc4_reg;
    valid_next      = valid_reg;
    skid_instr_next = skid_instr_reg;
    skid_pc4_next   = skid_pc4_reg;
    skid_valid_next = skid_valid_reg;

    // Consumed with nothing to replace it: present a NOP.
    if (consume) begin
      valid_next = 1'b0;
      instr_next = 32'h0000_0000;
    end

    if (Redirect) begin
      pc_next         = {Redirect_PC[31:2], 2'b00};
      valid_next      = 1'b0;
      instr_next      = 32'h0000_0000;
      skid_valid_next = 1'b0;
      case (state_reg)
        FETCH: begin
          if (ack) begin
            state_next = FETCH;
          end else begin
            state_next = DRAIN;
            stale_next = pc_reg;
          end
        end
        HOLD:    state_next = FETCH;
        DRAIN:   state_next = ack ? FETCH : DRAIN;
        default: state_next = FETCH;
      endcase
    end else begin
      case (state_reg)
        FETCH: begin
          if (ack) begin
            pc_next = pc_plus_4;
            if (room) begin
              instr_next = Imem_Rdata;
              pc4_next   = pc_plus_4;
              valid_next = 1'b1;
            end else begin
              skid_instr_next = Imem_Rdata;
              skid_pc4_next   = pc_plus_4;
              skid_valid_next = 1'b1;
              state_next      = HOLD;
            end
          end
        end
        HOLD: begin
          if (consume) begin
            instr_next      = skid_instr_reg;
            pc4_next        = skid_pc4_reg;
            valid_next      = skid_valid_reg;
            skid_valid_next = 1'b0;
            state_next      = FETCH;
          end
        end
        DRAIN: begin
          if (ack) state_next = FETCH;
        end
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      stale_reg      <= 32'h0000_0000;
      instr_reg      <= 32'h0000_0000;
      pc4_reg        <= 32'h0000_0000;
      valid_reg      <= 1'b0;
      skid_instr_reg <= 32'h0000_0000;
      skid_pc4_reg   <= 32'h0000_0000;
      skid_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      stale_reg      <= stale_next;
      instr_reg      <= instr_next;
      pc4_reg        <= pc4_next;
      valid_reg      <= valid_next;
      skid_instr_reg <= skid_instr_next;
      skid_pc4_reg   <= skid_pc4_next;
      skid_valid_reg <= skid_valid_next;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: expected instructions are queued as
// stimulus is applied and compared whenever the decode stage consumes one.
module tb_instruction_fetch_unit;

  logic        Clk;
  logic        Reset_n;
  logic        Stall_IF;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ack;
  logic [31:0] Imem_Rdata;
  logic [31:0] Instruction_IF;
  logic [31:0] PC_Plus_4_IF;
  logic        Valid_IF;

  logic        req2;
  logic [31:0] addr2;
  logic        ack2;
  logic [31:0] rdata2;
  logic [31:0] instr2;
  logic [31:0] pc4_2;
  logic        valid2;

  logic auto_ack;
  logic man_ack;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  // Memory model: returns the address as the instruction word.
  assign Imem_Ack   = auto_ack ? Imem_Req : man_ack;
  assign Imem_Rdata = Imem_Addr;
  assign ack2       = req2;
  assign rdata2     = addr2;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Stall_IF(Stall_IF), .Redirect(Redirect),
    .Redirect_PC(Redirect_PC), .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
    .Imem_Ack(Imem_Ack), .Imem_Rdata(Imem_Rdata), .Instruction_IF(Instruction_IF),
    .PC_Plus_4_IF(PC_Plus_4_IF), .Valid_IF(Valid_IF)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .Clk(Clk), .Reset_n(Reset_n), .Stall_IF(1'b0), .Redirect(1'b0),
    .Redirect_PC(32'h0000_0000), .Imem_Req(req2), .Imem_Addr(addr2),
    .Imem_Ack(ack2), .Imem_Rdata(rdata2), .Instruction_IF(instr2),
    .PC_Plus_4_IF(pc4_2), .Valid_IF(valid2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] addr);
    sb.push_back('{instr: addr, pc4: addr + 32'd4});
  endtask

  // One clock: scoreboard check mid-cycle, return 1 time unit after the edge.
  task automatic cycle();
    exp_t e;
    @(negedge Clk);
    if (Valid_IF && !Stall_IF) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL sb_extra: observed instr %h expected none", Instruction_IF);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("consume instr=%h pc4=%h (expect %h %h)", Instruction_IF, PC_Plus_4_IF, e.instr, e.pc4);
        check("sb_instr", Instruction_IF, e.instr);
        check("sb_pc4", PC_Plus_4_IF, e.pc4);
      end
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    Reset_n = 1'b0;
    Stall_IF = 1'b0;
    Redirect = 1'b0;
    Redirect_PC = 32'h0;
    auto_ack = 1'b1;
    man_ack = 1'b0;

    #2;
    check("rst_valid", {31'd0, Valid_IF}, 32'd0);
    check("rst_instr", Instruction_IF, 32'd0);
    check("rst_pc4", PC_Plus_4_IF, 32'd0);
    check("rst_req", {31'd0, Imem_Req}, 32'd0);

    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    #1;
    check("first_req", {31'd0, Imem_Req}, 32'd1);
    check("first_addr", Imem_Addr, 32'h0);
    check("wrap_first_addr", addr2, 32'hFFFF_FFFC);

    // Zero-wait stream.
    for (int i = 0; i < 8; i++) push(32'(i * 4));
    cycle();
    check("wrap_valid", {31'd0, valid2}, 32'd1);
    check("wrap_instr", instr2, 32'hFFFF_FFFC);
    check("wrap_pc4", pc4_2, 32'h0);
    check("wrap_second_addr", addr2, 32'h0);
    for (int i = 0; i < 7; i++) cycle();

    // Stall for three cycles while an ack returns.
    Stall_IF = 1'b1;
    push(32'd32);
    push(32'd36);
    push(32'd40);
    cycle();
    check("hold_req", {31'd0, Imem_Req}, 32'd0);
    check("hold_instr", Instruction_IF, 32'd28);
    check("hold_valid", {31'd0, Valid_IF}, 32'd1);
    cycle();
    cycle();
    check("hold_req3", {31'd0, Imem_Req}, 32'd0);
    Stall_IF = 1'b0;
    cycle();
    check("release_instr", Instruction_IF, 32'd32);
    check("release_addr", Imem_Addr, 32'd36);
    check("release_req", {31'd0, Imem_Req}, 32'd1);
    cycle();
    cycle();
    cycle();

    // Redirect coinciding with an ack while stalled.
    Stall_IF = 1'b1;
    Redirect = 1'b1;
    Redirect_PC = 32'h0000_0013;
    cycle();
    check("sim_valid", {31'd0, Valid_IF}, 32'd0);
    check("sim_instr", Instruction_IF, 32'd0);
    check("sim_addr", Imem_Addr, 32'h10);

    // Redirect while the request to 0x10 is pending; ack two cycles later.
    auto_ack = 1'b0;
    Stall_IF = 1'b0;
    Redirect_PC = 32'h0000_0102;
    cycle();
    Redirect = 1'b0;
    check("drain_req", {31'd0, Imem_Req}, 32'd1);
    check("drain_addr", Imem_Addr, 32'h10);
    check("drain_valid", {31'd0, Valid_IF}, 32'd0);
    cycle();
    check("drain_addr2", Imem_Addr, 32'h10);
    check("drain_valid2", {31'd0, Valid_IF}, 32'd0);
    man_ack = 1'b1;
    cycle();
    man_ack = 1'b0;
    check("drain_done_valid", {31'd0, Valid_IF}, 32'd0);
    check("drain_done_addr", Imem_Addr, 32'h100);
    auto_ack = 1'b1;
    push(32'h100);
    cycle();
    cycle();

    // Park in HOLD, then reset asynchronously.
    Stall_IF = 1'b1;
    cycle();
    check("hold2_req", {31'd0, Imem_Req}, 32'd0);
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, Valid_IF}, 32'd0);
    check("arst_instr", Instruction_IF, 32'd0);
    check("arst_pc4", PC_Plus_4_IF, 32'd0);
    check("arst_req", {31'd0, Imem_Req}, 32'd0);
    @(posedge Clk);
    #3;
    Stall_IF = 1'b0;
    Reset_n = 1'b1;
    #1;
    check("restart_req", {31'd0, Imem_Req}, 32'd1);
    check("restart_addr", Imem_Addr, 32'h0);
    push(32'h0);
    @(posedge Clk);
    #1;
    auto_ack = 1'b0;
    cycle();
    check("nop_valid", {31'd0, Valid_IF}, 32'd0);
    check("nop_instr", Instruction_IF, 32'd0);
    check("nop_pc4", PC_Plus_4_IF, 32'd4);
    check("nop_addr", Imem_Addr, 32'd4);
    check("sb_left", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have these ports, one per line:
  Clk  input  1  sole clock; all state updates on rising edge.
  Reset_n  input  1  reset, asynchronous and active-low.
  Stall_IF  input  1  hazard unit hold; the decode stage does not take Instruction_IF this cycle.
  Redirect  input  1  taken branch or jump; flush and restart fetch.
  Redirect_PC  input  32  restart address when Redirect=1.
  Imem_Req  output  1  instruction memory request.
  Imem_Addr  output  32  request address; word aligned.
  Imem_Ack  input  1  memory response valid this cycle.
  Imem_Rdata  input  32  instruction word; valid with Imem_Ack.
  Instruction_IF  output  32  fetched instruction to the IF/ID pipeline register.
  PC_Plus_4_IF  output  32  address of Instruction_IF plus 4.
  Valid_IF  output  1  Instruction_IF holds a real fetched instruction.

Function
REQ-003 State SHALL be one of FETCH, HOLD, DRAIN; PC register (next fetch address); a one-entry output register (Instruction_IF, PC_Plus_4_IF, Valid_IF); a one-entry skid buffer (instr, pc+4, valid).
REQ-004 Consume event SHALL be defined as Valid_IF=1 and Stall_IF=0 at a rising edge; room SHALL be defined as Valid_IF=0 or a consume event this cycle.
REQ-005 Memory protocol: once Imem_Req=1, Imem_Req and Imem_Addr SHALL stay stable until the cycle in which Imem_Ack=1; Imem_Ack with Imem_Req=0 SHALL be ignored.
REQ-006 FETCH: Imem_Req=1 and Imem_Addr=PC.
REQ-007 FETCH with Imem_Ack=1, Redirect=0, and room: next edge loads the output register with Imem_Rdata, PC+4, and valid; PC<=PC+4; state stays FETCH. Back-to-back acks SHALL give one instruction per cycle.
REQ-008 FETCH with Imem_Ack=1, Redirect=0, and no room: Imem_Rdata and PC+4 SHALL load the skid buffer; PC<=PC+4; next state HOLD.
REQ-009 HOLD: Imem_Req=0; on a consume event the skid entry SHALL move to the output register, the skid SHALL empty, and the next state SHALL be FETCH.
REQ-010 Consume event with no new data: Valid_IF<=0 and Instruction_IF<=32'h0000_0000 (NOP); PC_Plus_4_IF holds.
REQ-011 Redirect=1 SHALL take priority over Stall_IF and Imem_Ack. At the edge: PC<={Redirect_PC[31:2],2'b00}; output and skid valid<=0; Instruction_IF<=0.
REQ-012 Redirect in FETCH with Imem_Ack=0: the outstanding address SHALL be latched and the next state SHALL be DRAIN. Redirect with Imem_Ack=1 in FETCH, or Redirect in HOLD: the next state SHALL be FETCH, and any acked data SHALL be dropped.
REQ-013 DRAIN: Imem_Req=1 with Imem_Addr equal to the latched stale address. On Imem_Ack the data SHALL be dropped and the next state SHALL be FETCH at the current PC. A further Redirect in DRAIN SHALL update PC only.
REQ-014 PC+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC+4=32'h0000_0000. Imem_Addr[1:0] SHALL always be 2'b00.
REQ-015 Stall_IF SHALL NOT deassert Imem_Req; stalls are absorbed by the skid buffer and HOLD.
REQ-016 Valid_IF SHALL never be 1 for data of a request that was outstanding when Redirect was sampled.

Reset
REQ-017 While Reset_n=0: state=FETCH, PC=RESET_PC, Instruction_IF=0, PC_Plus_4_IF=0, Valid_IF=0, skid empty, and Imem_Req forced to 0.
REQ-018 Reset asserted mid-request SHALL abandon the request; the memory SHALL be reset by the same Reset_n.
REQ-019 On the first edge after Reset_n rises, the block SHALL assert Imem_Req with Imem_Addr=RESET_PC.

Verification
REQ-020 Stream: Imem_Ack held at 1 with zero wait; Rdata = address; no stall -> Instruction_IF sequence 0,4,8,...; PC_Plus_4_IF = Instruction_IF+4; one instruction per cycle.
REQ-021 Stall: Stall_IF=1 for 3 cycles while an ack returns -> the skid buffer captures the data, state is HOLD, Imem_Req=0; after release the instructions appear in order with none lost or duplicated.
REQ-022 Redirect drain: Redirect=1 with Redirect_PC=32'h0000_0102 while the request to 0x10 is pending and Imem_Ack arrives 2 cycles later -> Imem_Addr holds 0x10 until ack; that data is dropped; the next request is 0x100; Valid_IF=0 meanwhile.
REQ-023 Simultaneous events: Redirect and Imem_Ack in the same cycle with Stall_IF=1 -> acked data dropped; output flushed to 0; the next Imem_Addr is the redirect target.
REQ-024 Wrap: RESET_PC=32'hFFFF_FFFC -> the first PC_Plus_4_IF is 0 and the second request address is 0.
REQ-025 Async reset: Reset_n pulsed low mid-HOLD, not aligned to Clk -> outputs clear immediately and the fetch restarts at RESET_PC.
